// File: rtl/pc_unit_pkg.sv
// pc_pkg: shared types and default constants for the program-counter unit.
//   npc_sel_t     next-pc source chosen by the priority encoder
//   *_DEF         default reset/trap vectors and sequential increment
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        TRAP = 3'd5,
        TRET = 3'd6,
        HOLD = 3'd7
    } npc_sel_t;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
    localparam int          INC_DEF       = 4;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control and status bundle between decode/branch logic and the PC unit.
//   master : decode side, drives the control requests, observes pc/epc/flags
//   slave  : pc_unit side, consumes requests, drives pc/pc_plus/epc/in_trap/ras_*
interface pc_unit_if #(
    parameter int W     = 32,
    parameter int OFF_W = 16
);
    logic             stall;
    logic             br_taken;
    logic [OFF_W-1:0] br_offset;
    logic             jump;
    logic             call;
    logic             ret;
    logic [W-1:0]     jump_target;
    logic             trap;
    logic             trap_ret;

    logic [W-1:0]     pc;
    logic [W-1:0]     pc_plus;
    logic [W-1:0]     epc;
    logic             in_trap;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_err;

    modport master (
        output stall, br_taken, br_offset, jump, call, ret, jump_target, trap, trap_ret,
        input  pc, pc_plus, epc, in_trap, ras_full, ras_empty, ras_err
    );

    modport slave (
        input  stall, br_taken, br_offset, jump, call, ret, jump_target, trap, trap_ret,
        output pc, pc_plus, epc, in_trap, ras_full, ras_empty, ras_err
    );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack.
//   clock, reset      rising-edge clock, synchronous active-high reset
//   push_i, data_i    write data_i as the new top entry
//   pop_i             discard the top entry (ignored when empty)
//   top_o             current top entry
//   full_o, empty_o   count == DEPTH / count == 0
// push_i and pop_i must not be asserted together; the parent resolves that case.
// When full, a push overwrites the oldest entry and the count saturates.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            // pointer always advances; wrapping onto the oldest entry overwrites it
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_i) mem_q[ptr_d] <= data_i;
    end

    assign top_o   = mem_q[ptr_q];
    assign full_o  = (cnt_q == CNT_MAX);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-pc selection, return-address stack and trap EPC.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus (slave)   control requests in (stall, br_taken/br_offset, jump, call, ret,
//                 jump_target, trap, trap_ret); pc, pc_plus, epc, in_trap, ras_full,
//                 ras_empty, ras_err out
// Next-pc priority: trap (not in trap) > trap_ret (in trap) > stall > ret > call > jump
//                   > branch > sequential. All arithmetic wraps modulo 2^W.
module pc_unit
    import pc_pkg::*;
#(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VEC = W'(RESET_VEC_DEF),
    parameter logic [W-1:0] TRAP_VEC  = W'(TRAP_VEC_DEF),
    parameter int           INC       = INC_DEF,
    parameter int           OFF_W     = 16,
    parameter int           OFF_SHIFT = 2,
    parameter int           DEPTH     = 4
) (
    input  logic     clock,
    input  logic     reset,
    pc_unit_if.slave bus
);
    localparam logic [W-1:0] INC_W = W'(INC);

    npc_sel_t     sel;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] epc_q, epc_d;
    logic         in_trap_q, in_trap_d;
    logic         ras_err_q, ras_err_d;
    logic [W-1:0] pc_plus;
    logic [W-1:0] br_off_ext;
    logic         ras_push, ras_pop;
    logic [W-1:0] ras_top;
    logic         ras_full, ras_empty;

    assign pc_plus    = pc_q + INC_W;
    assign br_off_ext = {{(W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset} << OFF_SHIFT;

    // A request that is ignored in the current trap state falls through to the next level.
    always_comb begin
        sel = SEQ;
        if      (bus.trap && !in_trap_q)    sel = TRAP;
        else if (bus.trap_ret && in_trap_q) sel = TRET;
        else if (bus.stall)                 sel = HOLD;
        else if (bus.ret)                   sel = RET;
        else if (bus.call)                  sel = CALL;
        else if (bus.jump)                  sel = JMP;
        else if (bus.br_taken)              sel = BR;
    end

    always_comb begin
        pc_d      = pc_plus;
        epc_d     = epc_q;
        in_trap_d = in_trap_q;
        ras_err_d = ras_err_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        unique case (sel)
            TRAP: begin
                pc_d      = TRAP_VEC;
                epc_d     = pc_q;
                in_trap_d = 1'b1;
            end
            TRET: begin
                pc_d      = epc_q;
                in_trap_d = 1'b0;
            end
            HOLD: pc_d = pc_q;
            RET: begin
                // ret beats a simultaneous call; the dropped call is flagged as an error
                if (ras_empty) begin
                    pc_d      = bus.jump_target;
                    ras_err_d = 1'b1;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
                if (bus.call) ras_err_d = 1'b1;
            end
            CALL: begin
                pc_d     = bus.jump_target;
                ras_push = 1'b1;
            end
            JMP:     pc_d = bus.jump_target;
            BR:      pc_d = pc_plus + br_off_ext;
            default: pc_d = pc_plus;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_VEC;
            epc_q     <= '0;
            in_trap_q <= 1'b0;
            ras_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            in_trap_q <= in_trap_d;
            ras_err_q <= ras_err_d;
        end
    end

    ras_stack #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_plus),
        .top_o   (ras_top),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_plus   = pc_plus;
    assign bus.epc       = epc_q;
    assign bus.in_trap   = in_trap_q;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_err   = ras_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test of pc_unit against a behavioural model (RAS as a queue).
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;

    pc_unit_if #(.W(32), .OFF_W(16)) bus ();

    pc_unit #(
        .W         (32),
        .RESET_VEC (32'h0),
        .TRAP_VEC  (32'h100),
        .INC       (4),
        .OFF_W     (16),
        .OFF_SHIFT (2),
        .DEPTH     (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_epc;
    logic        m_in_trap, m_err;
    logic [31:0] m_ras[$];
    bit          m_valid = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = 32'h0; m_epc = 32'h0; m_in_trap = 0; m_err = 0;
            m_ras.delete();
            m_valid = 1;
        end else if (m_valid) begin
            if (bus.trap && !m_in_trap) begin
                m_epc = m_pc; m_pc = 32'h100; m_in_trap = 1;
            end else if (bus.trap_ret && m_in_trap) begin
                m_pc = m_epc; m_in_trap = 0;
            end else if (bus.stall) begin
                // hold
            end else if (bus.ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = bus.jump_target; m_err = 1; end
                if (bus.call) m_err = 1;
            end else if (bus.call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                m_pc = bus.jump_target;
            end else if (bus.jump) begin
                m_pc = bus.jump_target;
            end else if (bus.br_taken) begin
                m_pc = m_pc + 32'd4 + ({{16{bus.br_offset[15]}}, bus.br_offset} << 2);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("pc",        bus.pc,        m_pc);
            check("pc_plus",   bus.pc_plus,   m_pc + 32'd4);
            check("epc",       bus.epc,       m_epc);
            check("in_trap",   32'(bus.in_trap),   32'(m_in_trap));
            check("ras_full",  32'(bus.ras_full),  32'(m_ras.size() == DEPTH));
            check("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
            check("ras_err",   32'(bus.ras_err),   32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.stall = 0; bus.br_taken = 0; bus.br_offset = '0; bus.jump = 0;
        bus.call = 0; bus.ret = 0; bus.jump_target = '0; bus.trap = 0; bus.trap_ret = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic go_jump(input logic [31:0] tgt);
        idle(); bus.jump = 1; bus.jump_target = tgt;
        cyc();
        idle();
    endtask

    task automatic do_reset();
        reset = 1; idle();
        cyc();
        reset = 0;
    endtask

    logic [31:0] exp_ret[4];

    initial begin
        idle();
        reset = 1;
        // 1. reset, sequential run, mid-run reset
        repeat (3) cyc();
        check("t1_reset_pc", bus.pc, 32'h0);
        check("t1_reset_empty", 32'(bus.ras_empty), 32'd1);
        reset = 0;
        cyc(); check("t1_seq4",  bus.pc, 32'h4);
        cyc(); check("t1_seq8",  bus.pc, 32'h8);
        cyc(); check("t1_seq12", bus.pc, 32'hC);
        repeat (13) cyc();
        check("t1_pc40", bus.pc, 32'h40);
        reset = 1;
        cyc();
        check("t1_midreset_pc", bus.pc, 32'h0);
        check("t1_midreset_empty", 32'(bus.ras_empty), 32'd1);
        reset = 0;

        // 2. relative branches
        repeat (4) cyc();
        check("t2_pc10", bus.pc, 32'h10);
        bus.br_taken = 1; bus.br_offset = 16'hFFFE;
        cyc(); check("t2_br_neg", bus.pc, 32'h0C);
        bus.br_offset = 16'h7FFF;
        cyc(); check("t2_br_max", bus.pc, 32'h2000C);
        idle();

        // 3. nested call/return, then ret on empty
        go_jump(32'h20);
        bus.call = 1; bus.jump_target = 32'h100;
        cyc(); check("t3_call1", bus.pc, 32'h100);
        bus.jump_target = 32'h200;
        cyc(); check("t3_call2", bus.pc, 32'h200);
        idle(); bus.ret = 1;
        cyc(); check("t3_ret1", bus.pc, 32'h104);
        cyc(); check("t3_ret2", bus.pc, 32'h24);
        check("t3_err_before", 32'(bus.ras_err), 32'd0);
        bus.jump_target = 32'h300;
        cyc(); check("t3_ret_empty_pc", bus.pc, 32'h300);
        check("t3_ret_empty_err", 32'(bus.ras_err), 32'd1);
        idle();

        // 4. overflow: five calls from A=0 .. E=0x4000, A's return lost
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.call = 1; bus.jump_target = 32'(i) << 12;
            cyc();
        end
        idle();
        check("t4_full", 32'(bus.ras_full), 32'd1);
        exp_ret[0] = 32'h4004; exp_ret[1] = 32'h3004;
        exp_ret[2] = 32'h2004; exp_ret[3] = 32'h1004;
        bus.ret = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(); check("t4_ret", bus.pc, exp_ret[i]);
        end
        idle();
        check("t4_empty", 32'(bus.ras_empty), 32'd1);
        check("t4_no_err", 32'(bus.ras_err), 32'd0);

        // 5. trap under stall, nested trap ignored, trap return
        go_jump(32'h50);
        bus.stall = 1; bus.trap = 1;
        cyc();
        check("t5_trap_pc", bus.pc, 32'h100);
        check("t5_trap_epc", bus.epc, 32'h50);
        check("t5_in_trap", 32'(bus.in_trap), 32'd1);
        bus.stall = 0;
        cyc();
        check("t5_trap2_pc", bus.pc, 32'h104);
        check("t5_trap2_epc", bus.epc, 32'h50);
        idle(); bus.trap_ret = 1;
        cyc();
        check("t5_tret_pc", bus.pc, 32'h50);
        check("t5_tret_flag", 32'(bus.in_trap), 32'd0);
        cyc();
        check("t5_tret_ignored", bus.pc, 32'h54);
        idle();

        // 6. wrap, stall hold, call+ret collision
        do_reset();
        go_jump(32'hFFFF_FFFC);
        cyc(); check("t6_wrap", bus.pc, 32'h0);
        bus.stall = 1; bus.call = 1; bus.jump_target = 32'h900;
        repeat (3) cyc();
        check("t6_stall_pc", bus.pc, 32'h0);
        check("t6_stall_empty", 32'(bus.ras_empty), 32'd1);
        idle(); bus.call = 1; bus.jump_target = 32'h600;
        cyc(); check("t6_call", bus.pc, 32'h600);
        bus.ret = 1; bus.jump_target = 32'h700;
        cyc();
        check("t6_callret_pc", bus.pc, 32'h4);
        check("t6_callret_err", 32'(bus.ras_err), 32'd1);
        check("t6_callret_empty", 32'(bus.ras_empty), 32'd1);
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
